fetch_unit: RTL
===============

# fetch_unit

Opcode fetch stage directly upstream of `top`'s decoder/register file. Runs the Game Boy M1 (opcode fetch) machine cycle as four T-states, drives the memory read address from its program counter, and collapses a `CB` prefix plus its following byte into one extended opcode. Delivers `op_next` with a valid/ready handshake and produces the `m1t1` strobe the rest of the CPU and the benches synchronise on.

## Interface
- `ADDR_WIDTH`, 16, program counter / memory address width
- `DATA_WIDTH`, 8, memory data and opcode width
- `RESET_PC`, 16'h0000, PC value loaded by reset

- `clk`  in  1  system clock, one T-state per rising edge
- `rst`  in  1  reset; asynchronous, active-low
- `mem_addr`  out  ADDR_WIDTH  read address, equals PC during T1–T3
- `mem_rd`  out  1  read strobe, high during T1–T3
- `mem_data`  in  DATA_WIDTH  read data, sampled at the edge ending T3
- `mem_wait`  in  1  wait request; extends T2 while high
- `op_next`  out  DATA_WIDTH  fetched opcode (second byte when prefixed)
- `op_ext`  out  1  high when `op_next` followed a `CB` prefix
- `op_valid`  out  1  opcode available
- `op_ready`  in  1  decoder accepts opcode
- `pc_load`  in  1  replace next fetch address (jumps/calls)
- `pc_load_val`  in  ADDR_WIDTH  new PC value
- `pc`  out  ADDR_WIDTH  current program counter
- `m1t1`  out  1  one-cycle pulse in T1 of every M1 cycle
- `tstate`  out  2  current T-state index (0=T1 … 3=T4)

## Operation
- States: IDLE, T1, T2, T3, T4. All outputs registered.
- Reset (`rst`=0, any time, including mid-fetch): state IDLE, `pc`=RESET_PC, `mem_addr`=0, `mem_rd`=0, `op_next`=0, `op_ext`=0, `op_valid`=0, `m1t1`=0, `tstate`=0, prefix flag cleared.
- IDLE → T1 on the first edge after `rst` goes high.
- T1: `m1t1`=1, `mem_rd`=1, `mem_addr`=`pc`. → T2.
- T2: `mem_rd`=1. Stay in T2 while `mem_wait`=1; else → T3.
- T3: `mem_rd`=1. On the edge leaving T3: latch `mem_data`, `pc`←`pc`+1 (wraps FFFF→0000).
  - Byte = 8'hCB and prefix flag clear: set prefix flag, no `op_valid`, → T4 then T1 (second fetch).
  - Otherwise: `op_next`←byte, `op_ext`←prefix flag, `op_valid`←1, clear prefix flag, → T4.
- T4 with `op_valid`=1: hold T4, `op_next`/`op_ext` stable, until `op_ready`=1. The handshake edge clears `op_valid` and moves to T1.
- `CB CB` is legal: the second `CB` is delivered as `op_next`=CB, `op_ext`=1.
- `pc_load` honoured only on the handshake edge (`op_valid`&`op_ready`). It overrides the already-incremented PC for the next T1. Ignored at all other times.
- `op_ready` with `op_valid`=0 has no effect.

## Timing
- Unprefixed fetch with zero waits and `op_ready` held high: 4 cycles T1→T1. `op_valid` is high for exactly the T4 cycle.
- Prefixed fetch: 8 cycles, two `m1t1` pulses, one `op_valid`.
- Each `mem_wait` cycle adds one T2 cycle. `tstate` stays 1 during it.
- Stall: every cycle of `op_ready`=0 in T4 adds one cycle. No new `mem_rd` is issued during the stall.
- `pc` output updates on the edge leaving T3, and on the handshake edge when `pc_load` is set.

## Structure
- Shared package `gb_pkg`: T-state enum/localparams, `CB_PREFIX`=8'hCB, default `RESET_PC`, address/data width constants. `top` uses the same constants.
- One sub-module `pc_reg`: PC register with increment, load and async active-low reset; load has priority over increment.
- Sequencer FSM and opcode/prefix latch stay in `fetch_unit`.

## Test plan
- Reset/startup: memory 0x0000=8'h3E, `op_ready`=1 → after release, `m1t1` at first T1, `mem_addr`=0000; `op_valid` 3 cycles later with `op_next`=3E, `op_ext`=0, `pc`=0001.
- Prefix: memory 0x0010=CB, 0x0011=37, start PC 0010 → two `m1t1` pulses; single `op_valid` with `op_next`=37, `op_ext`=1, `pc`=0012; `CB CB` pair → `op_next`=CB, `op_ext`=1.
- Wait/stall: `mem_wait` high 3 cycles in T2 → `tstate`=1 held 4 cycles, byte still correct. `op_ready` low 5 cycles → `op_valid` and `op_next` stable, `mem_rd`=0 throughout.
- Jump and wrap: `pc_load`=1, `pc_load_val`=C000 on handshake → next `mem_addr`=C000. Fetch at FFFF → `pc`=0000 after T3.
- Reset mid-fetch: drop `rst` during T2 of a prefixed second fetch → all outputs at reset values immediately. After release, fetch restarts at RESET_PC with `op_ext`=0.

Source files
------------

// File: rtl/gb_pkg.sv
// Constants and types shared by the opcode fetch stage and the rest of the CPU:
// bus widths, the CB prefix byte, and the M1 T-state sequencer states.
package gb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0000;
    localparam logic [DATA_W-1:0] CB_PREFIX = 8'hCB;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4
    } fetch_state_t;

    // T-state index as seen by the rest of the CPU (IDLE reports as T1).
    function automatic logic [1:0] tstate_of(fetch_state_t s);
        case (s)
            ST_T2:   return 2'd1;
            ST_T3:   return 2'd2;
            ST_T4:   return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Memory read is driven during T1..T3 only.
    function automatic logic is_bus_phase(fetch_state_t s);
        return (s == ST_T1) || (s == ST_T2) || (s == ST_T3);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Memory read bus and opcode handshake between the fetch stage and its neighbours.
// op_valid/op_ready: a transfer happens on a rising edge where both are high;
// op_valid never drops and op_next/op_ext never change until that edge.
interface fetch_unit_if #(
    parameter int ADDR_WIDTH = gb_pkg::ADDR_W,
    parameter int DATA_WIDTH = gb_pkg::DATA_W
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_wait;
    logic [DATA_WIDTH-1:0] op_next;
    logic                  op_ext;
    logic                  op_valid;
    logic                  op_ready;

    modport master (
        output mem_addr, mem_rd, op_next, op_ext, op_valid,
        input  mem_data, mem_wait, op_ready
    );

    modport slave (
        input  mem_addr, mem_rd, op_next, op_ext, op_valid,
        output mem_data, mem_wait, op_ready
    );
endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter with increment and load; load wins over increment.
// pc_next exposes the value the register takes on the coming edge.
module pc_reg #(
    parameter int                    ADDR_WIDTH = gb_pkg::ADDR_W,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = gb_pkg::RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_val,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_next
);

    always_comb begin
        pc_next = pc;
        if (load) begin
            pc_next = load_val;
        end else if (inc) begin
            pc_next = pc + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// M1 opcode fetch stage: sequences T1..T4, reads memory at PC and folds a CB
// prefix plus its following byte into one extended opcode for the decoder.
module fetch_unit
    import gb_pkg::*;
#(
    parameter int                    ADDR_WIDTH = gb_pkg::ADDR_W,
    parameter int                    DATA_WIDTH = gb_pkg::DATA_W,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = gb_pkg::RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_unit_if.master          bus,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_val,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  m1t1,
    output logic [1:0]            tstate,
    output fetch_state_t          fsm_state
);

    fetch_state_t          state_q, state_d;
    logic                  handshake;
    logic                  pc_inc, pc_ld;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  mem_rd_q;
    logic [DATA_WIDTH-1:0] op_next_q;
    logic                  op_ext_q, op_valid_q, prefix_q;

    assign handshake = (state_q == ST_T4) && op_valid_q && bus.op_ready;

    pc_reg #(.ADDR_WIDTH(ADDR_WIDTH), .RESET_PC(RESET_PC)) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .inc      (pc_inc),
        .load     (pc_ld),
        .load_val (pc_load_val),
        .pc       (pc),
        .pc_next  (pc_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_inc  = 1'b0;
        pc_ld   = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_T1;
            ST_T1:   state_d = ST_T2;
            ST_T2:   if (!bus.mem_wait) state_d = ST_T3;
            ST_T3: begin
                state_d = ST_T4;
                pc_inc  = 1'b1;
            end
            ST_T4: begin
                // A prefix byte leaves op_valid low, so T4 falls straight through.
                if (!op_valid_q) begin
                    state_d = ST_T1;
                end else if (bus.op_ready) begin
                    state_d = ST_T1;
                    pc_ld   = pc_load;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            m1t1       <= 1'b0;
            tstate     <= 2'd0;
            op_next_q  <= '0;
            op_ext_q   <= 1'b0;
            op_valid_q <= 1'b0;
            prefix_q   <= 1'b0;
        end else begin
            mem_rd_q <= is_bus_phase(state_d);
            m1t1     <= (state_d == ST_T1);
            tstate   <= tstate_of(state_d);
            if (state_d == ST_T1) begin
                mem_addr_q <= pc_next;
            end
            if (state_q == ST_T3) begin
                if ((bus.mem_data == DATA_WIDTH'(CB_PREFIX)) && !prefix_q) begin
                    prefix_q <= 1'b1;
                end else begin
                    op_next_q  <= bus.mem_data;
                    op_ext_q   <= prefix_q;
                    op_valid_q <= 1'b1;
                    prefix_q   <= 1'b0;
                end
            end
            if (handshake) begin
                op_valid_q <= 1'b0;
            end
        end
    end

    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_rd   = mem_rd_q;
    assign bus.op_next  = op_next_q;
    assign bus.op_ext   = op_ext_q;
    assign bus.op_valid = op_valid_q;
    assign fsm_state    = state_q;

endmodule
